instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the instruction memory write port (write_enable / address / write_data).
- Takes a byte stream from the UART receiver, assembles big-endian 32-bit words and writes them into instruction memory at consecutive word addresses starting at 0.
- Holds the CPU-side "program loaded" handshake: busy while loading, a one-cycle done pulse at the end, and a sticky error flag.

Parameters:
- MEM_SIZE, 20000, number of 32-bit words in instruction memory; the upper bound on the word count in the header.
- ADDR_WIDTH, 16, width of the address output; must satisfy 2^ADDR_WIDTH >= MEM_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms the loader from IDLE, DONE or ERROR.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- write_enable  out  1  one-cycle write strobe to instruction memory.
- address  out  ADDR_WIDTH  word address of the current write.
- write_data  out  32  word to write.
- busy  out  1  loader is armed and has not finished.
- done  out  1  one-cycle pulse after the final word is written.
- error  out  1  sticky; the header word count exceeded MEM_SIZE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - write_enable=0, address=0, write_data=0, busy=0, done=0, error=0.
  - Byte and word counters cleared.
  - Memory already written is left as is; a reset mid-load abandons the load with no further writes.
- Stream format:
  - 4-byte header: word count N, big-endian (first byte goes to bits [31:24]).
  - Then N words, 4 bytes each, big-endian.
- All outputs are registered.
- States:
  - IDLE: busy=0. rx_valid is ignored. start -> HEADER.
  - HEADER: busy=1. Each rx_valid shifts in one byte. On the 4th byte the full 32-bit N is compared:
    - N==0 -> DONE.
    - N>MEM_SIZE -> ERROR.
    - otherwise -> PAYLOAD, with word index k=0.
  - PAYLOAD: busy=1. On the 4th byte of a word, the next cycle has write_enable=1, address=k, write_data=assembled word, for exactly one cycle. k then increments.
    - After the write of word N-1 -> DONE.
    - The comparison uses a 32-bit counter; address is its low ADDR_WIDTH bits.
  - DONE: done=1 and busy=0 for one cycle, occurring the cycle after the final write_enable (or after the header when N==0). Next cycle -> IDLE.
  - ERROR: error=1 and busy=0. No writes; bytes are ignored. start clears error and goes -> HEADER.
- Latency: write_enable rises exactly 1 cycle after the rx_valid cycle carrying the word's last byte.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss. At most one write occurs per 4 cycles.
- Between writes, write_data and address hold their last values. write_enable=0.
- start while in HEADER or PAYLOAD is ignored.
- start and rx_valid in the same cycle from IDLE/DONE/ERROR: start takes effect and the byte is dropped.
- A partial word still pending when reset asserts is discarded.

Decomposition:
- Shared package instruction_loader_pkg:
  - state enum: IDLE, HEADER, PAYLOAD, DONE, ERROR.
  - BYTES_PER_WORD=4, HEADER_BYTES=4.
- One sub-module, byte_assembler:
  - 2-bit byte counter plus a 32-bit big-endian shift register.
  - Outputs word and word_valid (1-cycle pulse on the 4th byte).
  - Has a clear input, driven on start and reset.
  - Used for both the header and the payload.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 00 00 00 02, DE AD BE EF, 01 23 45 67.
  - Response: writes (0, DEADBEEF) then (1, 01234567), each exactly 1 cycle after the 4th byte. done pulses the cycle after the 2nd write. busy falls with done.
- Empty program:
  - Stimulus: start, header 00 00 00 00.
  - Response: no write_enable; done pulses the cycle after the 4th header byte.
- Oversize program:
  - Stimulus: start, header 00 00 4E 21 (20001).
  - Response: error=1 and held; busy=0; no writes even with further bytes. A second start clears error and a valid load then succeeds.
- Idle/ignore rules:
  - Stimulus: bytes with no prior start; then start and rx_valid in the same cycle.
  - Response: zero writes; the first byte counted is the one after the start cycle.
- Back-to-back stream:
  - Stimulus: rx_valid every cycle for a header plus 3 words.
  - Response: 3 writes, 4 cycles apart, addresses 0, 1, 2, with correct data.
- Reset mid-word:
  - Stimulus: rst_n low after 2 bytes of word 1.
  - Response: all outputs 0 immediately, no further write. A new start followed by a full stream writes again from address 0.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: loader states and
// stream framing sizes.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int HEADER_BYTES   = 4;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Collects bytes into big-endian 32-bit words; word/word_valid are presented
// combinationally in the same cycle as the byte that completes the word.
module byte_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    // Next byte count and shift contents; clear wins over an incoming byte.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (byte_valid) begin
            cnt_d      = cnt_q + 2'd1;
            shift_d    = {shift_q[23:0], byte_in};
            word_valid = (cnt_q == LAST_BYTE);
        end else begin
            cnt_d   = cnt_q;
            shift_d = shift_q;
        end
    end

    assign word = shift_d;

    // Byte counter and shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a UART byte stream (big-endian word count, then that many big-endian
// words) into instruction memory from address 0 and reports busy/done/error.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MEM_SIZE   = 20000,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    state_e                  state_q, state_d;
    logic [31:0]             count_q, count_d;
    logic [31:0]             k_q, k_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    armable_s;
    logic                    start_accept_s;
    logic                    loading_s;
    logic                    byte_valid_s;
    logic                    word_valid_s;
    logic [31:0]             word_s;

    assign armable_s      = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
    assign start_accept_s = start && armable_s;
    assign loading_s      = (state_q == HEADER) || (state_q == PAYLOAD);
    assign byte_valid_s   = rx_valid && loading_s;

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_accept_s),
        .byte_valid (byte_valid_s),
        .byte_in    (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Next-state and next-output computation for the load sequence.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start_accept_s) state_d = HEADER;
                else                state_d = IDLE;
            end
            HEADER: begin
                if (word_valid_s) begin
                    if (word_s == 32'd0) begin
                        state_d = DONE;
                    end else if (word_s > MEM_LIMIT) begin
                        state_d = ERROR;
                    end else begin
                        state_d = PAYLOAD;
                        count_d = word_s;
                        k_d     = 32'd0;
                    end
                end else begin
                    state_d = HEADER;
                end
            end
            PAYLOAD: begin
                // Leave one cycle after the last write so done trails it.
                if (k_q == count_q) begin
                    state_d = DONE;
                end else if (word_valid_s) begin
                    we_d    = 1'b1;
                    addr_d  = k_q[ADDR_WIDTH-1:0];
                    wdata_d = word_s;
                    k_d     = k_q + 32'd1;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            DONE: begin
                if (start_accept_s) state_d = HEADER;
                else                state_d = IDLE;
            end
            ERROR: begin
                if (start_accept_s) state_d = HEADER;
                else                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d == HEADER) || (state_d == PAYLOAD);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERROR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 32'd0;
            k_q     <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            k_q     <= k_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign write_enable = we_q;
    assign address      = addr_q;
    assign write_data   = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized byte streams for instruction_loader, checked against
// a stream-level model of the expected writes and done/error handshake.
module tb_instruction_loader;

    localparam int MEM_SIZE   = 20000;
    localparam int ADDR_WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           write_data;
    logic                  busy;
    logic                  done;
    logic                  error;

    instruction_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    int                    wr_cyc_q[$];
    logic [ADDR_WIDTH-1:0] wr_addr_q[$];
    logic [31:0]           wr_data_q[$];
    int                    done_cyc_q[$];
    bit                    done_busy_q[$];
    logic                  prev_busy = 1'b0;
    logic [7:0]            prog[$];

    // Log every memory write and done pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_enable) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(address);
                wr_data_q.push_back(write_data);
            end
            if (done) begin
                done_cyc_q.push_back(cyc);
                done_busy_q.push_back(!busy && prev_busy);
            end
        end
        prev_busy <= busy;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cyc_q.delete();
        done_busy_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic build_prog(input int n);
        logic [31:0] w;
        logic [31:0] nw;
        nw = 32'(n);
        prog.delete();
        prog.push_back(nw[31:24]);
        prog.push_back(nw[23:16]);
        prog.push_back(nw[15:8]);
        prog.push_back(nw[7:0]);
        for (int j = 0; j < n; j++) begin
            w = $urandom;
            prog.push_back(w[31:24]);
            prog.push_back(w[23:16]);
            prog.push_back(w[15:8]);
            prog.push_back(w[7:0]);
        end
    endtask

    // Arm the loader, stream prog with random gaps and check the result
    // against what the stream itself dictates.
    task automatic run_load(input int max_gap, input bit with_byte, input int mid_start_idx);
        int          bc[$];
        logic [31:0] n;
        logic [31:0] w;
        int          nw;
        int          exp_done;
        clear_logs();
        start = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_data  = 8'hFF;
        end
        tick;
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("error_after_start", {63'd0, error}, 64'd0);
        for (int i = 0; i < prog.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) tick;
            if (i == mid_start_idx) start = 1'b1;
            bc.push_back(cyc);
            send_byte(prog[i]);
            start = 1'b0;
        end
        repeat (12) tick;
        n = {prog[0], prog[1], prog[2], prog[3]};
        if (n > MEM_SIZE) begin
            chk("err_flag", {63'd0, error}, 64'd1);
            chk("err_busy", {63'd0, busy}, 64'd0);
            chk("err_writes", 64'(wr_cyc_q.size()), 64'd0);
            chk("err_done", 64'(done_cyc_q.size()), 64'd0);
        end else begin
            nw = int'(n);
            chk("wr_count", 64'(wr_cyc_q.size()), 64'(nw));
            for (int j = 0; j < nw && j < wr_cyc_q.size(); j++) begin
                w = {prog[4+4*j], prog[5+4*j], prog[6+4*j], prog[7+4*j]};
                chk("wr_addr", 64'(wr_addr_q[j]), 64'(j));
                chk("wr_data", 64'(wr_data_q[j]), 64'(w));
                chk("wr_cycle", 64'(wr_cyc_q[j]), 64'(bc[7+4*j] + 1));
            end
            exp_done = (nw == 0) ? bc[3] + 1 : bc[3 + 4*nw] + 2;
            chk("done_count", 64'(done_cyc_q.size()), 64'd1);
            if (done_cyc_q.size() > 0) begin
                chk("done_cycle", 64'(done_cyc_q[0]), 64'(exp_done));
                chk("busy_falls_with_done", {63'd0, done_busy_q[0]}, 64'd1);
            end
            chk("busy_end", {63'd0, busy}, 64'd0);
            chk("error_end", {63'd0, error}, 64'd0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick;
        chk("rst_we", {63'd0, write_enable}, 64'd0);
        chk("rst_addr", 64'(address), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        rst_n = 1'b1;
        tick;

        // Bytes without a start are ignored.
        clear_logs();
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        repeat (4) tick;
        chk("idle_writes", 64'(wr_cyc_q.size()), 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        prog = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                 8'h01, 8'h23, 8'h45, 8'h67};
        run_load(2, 1'b0, -1);

        prog = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load(1, 1'b0, -1);

        prog = '{8'h00, 8'h00, 8'h4E, 8'h21};
        run_load(1, 1'b0, -1);
        clear_logs();
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
        repeat (4) tick;
        chk("err_extra_writes", 64'(wr_cyc_q.size()), 64'd0);
        chk("err_sticky", {63'd0, error}, 64'd1);
        build_prog(2);
        run_load(1, 1'b0, -1);

        // start with a byte in the same cycle: that byte is dropped.
        prog = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_load(0, 1'b1, -1);

        build_prog(3);
        run_load(0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            build_prog($urandom_range(1, 5));
            run_load($urandom_range(0, 3), 1'b0, (r % 2 == 0) ? 5 : -1);
        end

        // Reset two bytes into the second word.
        clear_logs();
        start = 1'b1;
        tick;
        start = 1'b0;
        prog = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                 8'h01, 8'h23};
        for (int i = 0; i < prog.size(); i++) send_byte(prog[i]);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", {63'd0, write_enable}, 64'd0);
        chk("midrst_addr", 64'(address), 64'd0);
        chk("midrst_data", 64'(write_data), 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        send_byte(8'h45);
        send_byte(8'h67);
        repeat (4) tick;
        chk("midrst_writes", 64'(wr_cyc_q.size()), 64'd1);
        build_prog(2);
        run_load(1, 1'b0, -1);

        // A header equal to MEM_SIZE is accepted.
        prog = '{8'h00, 8'h00, 8'h4E, 8'h20};
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        repeat (3) tick;
        chk("max_busy", {63'd0, busy}, 64'd1);
        chk("max_error", {63'd0, error}, 64'd0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
